// File: rtl/dmem_bridge_pkg.sv
// Shared types for the LSU-to-bus data memory bridge.
package dmem_bridge_pkg;

  localparam int unsigned BUS_WIDTH = 64;
  localparam int unsigned BUS_BYTES = BUS_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ_LO,
    WAIT_LO,
    REQ_HI,
    WAIT_HI,
    RESP
  } dmem_bridge_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment: splits an unaligned store into lo/hi beats and
// realigns a (possibly two-beat) load back to the request address.
module dmem_lane_align
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [2:0]           off,
  input  logic [3:0]           nbytes,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [WIDTH-1:0]     rd_lo,
  input  logic [WIDTH-1:0]     rd_hi,
  output logic                 split_c,
  output logic [BUS_BYTES-1:0] lo_strb_c,
  output logic [BUS_BYTES-1:0] hi_strb_c,
  output logic [WIDTH-1:0]     lo_wdata_c,
  output logic [WIDTH-1:0]     hi_wdata_c,
  output logic [WIDTH-1:0]     rd_data_c
);

  localparam int unsigned MW = 2 * BUS_BYTES;

  logic [MW-1:0]      mask;
  logic [MW-1:0]      mask_sh;
  logic [2*WIDTH-1:0] wr_sh;
  logic [5:0]         bit_off;

  // Shifting into a double-width word yields both beats at once.
  always_comb begin
    bit_off    = {off, 3'b000};
    mask       = (MW'(1) << nbytes) - MW'(1);
    mask_sh    = mask << off;
    wr_sh      = {WIDTH'(0), wr_data} << bit_off;
    split_c    = (5'(off) + 5'(nbytes)) > 5'(BUS_BYTES);
    lo_strb_c  = mask_sh[BUS_BYTES-1:0];
    hi_strb_c  = mask_sh[MW-1:BUS_BYTES];
    lo_wdata_c = wr_sh[WIDTH-1:0];
    hi_wdata_c = wr_sh[2*WIDTH-1:WIDTH];
    rd_data_c  = WIDTH'({rd_hi, rd_lo} >> bit_off);
  end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges single-cycle LSU load/store strobes onto an 8-byte-aligned
// valid/ready bus, splitting accesses that cross a bus word into two beats.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned FETCH_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dmem_rd_en_i,
  input  logic                   dmem_wr_en_i,
  input  logic [DATA_WIDTH-1:0]  dmem_addr_i,
  input  logic [2:0]             dmem_wr_size_i,
  input  logic [FETCH_WIDTH-1:0] dmem_wr_data_i,
  output logic                   dmem_busy_o,
  output logic                   dmem_rdy_o,
  output logic [FETCH_WIDTH-1:0] dmem_rd_data_o,
  output logic                   bus_req_valid_o,
  input  logic                   bus_req_ready_i,
  output logic                   bus_req_we_o,
  output logic [DATA_WIDTH-1:0]  bus_req_addr_o,
  output logic [BUS_BYTES-1:0]   bus_req_strb_o,
  output logic [FETCH_WIDTH-1:0] bus_req_wdata_o,
  input  logic                   bus_resp_valid_i,
  input  logic [FETCH_WIDTH-1:0] bus_resp_rdata_i
);

  dmem_bridge_state_t state, state_next;

  logic [2:0]             off_q;
  logic [3:0]             nbytes_q;
  logic                   we_q;
  logic [FETCH_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0]  addr_lo_q;
  logic [FETCH_WIDTH-1:0] rd_lo_q;

  logic                   idle, accept, in_we;
  logic [3:0]             in_nbytes;
  logic [2:0]             sel_off;
  logic [3:0]             sel_nbytes;
  logic [FETCH_WIDTH-1:0] sel_wdata, sel_rd_lo, sel_rd_hi;

  logic                   split;
  logic [BUS_BYTES-1:0]   lo_strb, hi_strb;
  logic [FETCH_WIDTH-1:0] lo_wdata, hi_wdata, rd_align;

  logic                   busy_n, rdy_n, valid_n, we_n;
  logic [DATA_WIDTH-1:0]  addr_n;
  logic [BUS_BYTES-1:0]   strb_n;
  logic [FETCH_WIDTH-1:0] wdata_n, rd_data_n;

  // Lane logic sees the live request while idle, the captured one otherwise.
  always_comb begin
    idle       = (state == IDLE);
    accept     = idle && (dmem_rd_en_i || dmem_wr_en_i);
    in_we      = dmem_wr_en_i;
    in_nbytes  = !in_we ? 4'd8 :
                 (dmem_wr_size_i >= 3'd3) ? 4'd8 : 4'(4'd1 << dmem_wr_size_i[1:0]);
    sel_off    = idle ? dmem_addr_i[2:0] : off_q;
    sel_nbytes = idle ? in_nbytes : nbytes_q;
    sel_wdata  = idle ? dmem_wr_data_i : wdata_q;
    sel_rd_lo  = (state == WAIT_LO) ? bus_resp_rdata_i : rd_lo_q;
    sel_rd_hi  = (state == WAIT_HI) ? bus_resp_rdata_i : '0;
  end

  dmem_lane_align #(.WIDTH(FETCH_WIDTH)) u_align (
    .off        (sel_off),
    .nbytes     (sel_nbytes),
    .wr_data    (sel_wdata),
    .rd_lo      (sel_rd_lo),
    .rd_hi      (sel_rd_hi),
    .split_c    (split),
    .lo_strb_c  (lo_strb),
    .hi_strb_c  (hi_strb),
    .lo_wdata_c (lo_wdata),
    .hi_wdata_c (hi_wdata),
    .rd_data_c  (rd_align)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_next = state;
    we_n       = bus_req_we_o;
    addr_n     = bus_req_addr_o;
    strb_n     = bus_req_strb_o;
    wdata_n    = bus_req_wdata_o;
    rd_data_n  = dmem_rd_data_o;

    case (state)
      IDLE:    if (accept) state_next = REQ_LO;
      REQ_LO:  if (bus_req_valid_o && bus_req_ready_i) state_next = WAIT_LO;
      WAIT_LO: if (bus_resp_valid_i) state_next = split ? REQ_HI : RESP;
      REQ_HI:  if (bus_req_valid_o && bus_req_ready_i) state_next = WAIT_HI;
      WAIT_HI: if (bus_resp_valid_i) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (accept) begin
      we_n    = in_we;
      addr_n  = {dmem_addr_i[DATA_WIDTH-1:3], 3'b000};
      strb_n  = in_we ? lo_strb : '1;
      wdata_n = in_we ? lo_wdata : '0;
    end else if (state == WAIT_LO && state_next == REQ_HI) begin
      addr_n  = addr_lo_q + DATA_WIDTH'(BUS_BYTES);
      strb_n  = we_q ? hi_strb : '1;
      wdata_n = we_q ? hi_wdata : '0;
    end

    if (state != RESP && state_next == RESP) rd_data_n = rd_align;

    busy_n  = (state_next != IDLE);
    rdy_n   = (state_next == RESP);
    valid_n = (state_next == REQ_LO) || (state_next == REQ_HI);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Captured request context and read low beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q     <= '0;
      nbytes_q  <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      addr_lo_q <= '0;
      rd_lo_q   <= '0;
    end else begin
      if (accept) begin
        off_q     <= dmem_addr_i[2:0];
        nbytes_q  <= in_nbytes;
        we_q      <= in_we;
        wdata_q   <= dmem_wr_data_i;
        addr_lo_q <= {dmem_addr_i[DATA_WIDTH-1:3], 3'b000};
      end
      if (state == WAIT_LO && bus_resp_valid_i) rd_lo_q <= bus_resp_rdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_busy_o     <= 1'b0;
      dmem_rdy_o      <= 1'b0;
      dmem_rd_data_o  <= '0;
      bus_req_valid_o <= 1'b0;
      bus_req_we_o    <= 1'b0;
      bus_req_addr_o  <= '0;
      bus_req_strb_o  <= '0;
      bus_req_wdata_o <= '0;
    end else begin
      dmem_busy_o     <= busy_n;
      dmem_rdy_o      <= rdy_n;
      dmem_rd_data_o  <= rd_data_n;
      bus_req_valid_o <= valid_n;
      bus_req_we_o    <= we_n;
      bus_req_addr_o  <= addr_n;
      bus_req_strb_o  <= strb_n;
      bus_req_wdata_o <= wdata_n;
    end
  end

  // The LSU must not strobe while a request is in flight; such strobes are dropped.
  a_no_strobe_when_busy: assert property (@(posedge clk) disable iff (rst)
    (state != IDLE) |-> !(dmem_rd_en_i || dmem_wr_en_i))
    else $error("dmem_bridge: LSU strobe while busy, dropped");

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: acts as LSU and bus, checks every beat.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [63:0] addr;
  logic [2:0]  size;
  logic [63:0] wr_data;
  logic        busy, rdy;
  logic [63:0] rd_data;
  logic        req_valid, req_ready, req_we;
  logic [63:0] req_addr;
  logic [7:0]  req_strb;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_bridge #(.DATA_WIDTH(64), .FETCH_WIDTH(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .dmem_rd_en_i     (rd_en),
    .dmem_wr_en_i     (wr_en),
    .dmem_addr_i      (addr),
    .dmem_wr_size_i   (size),
    .dmem_wr_data_i   (wr_data),
    .dmem_busy_o      (busy),
    .dmem_rdy_o       (rdy),
    .dmem_rd_data_o   (rd_data),
    .bus_req_valid_o  (req_valid),
    .bus_req_ready_i  (req_ready),
    .bus_req_we_o     (req_we),
    .bus_req_addr_o   (req_addr),
    .bus_req_strb_o   (req_strb),
    .bus_req_wdata_o  (req_wdata),
    .bus_resp_valid_i (resp_valid),
    .bus_resp_rdata_i (resp_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic we, input logic [63:0] a,
                          input logic [7:0] s, input logic [63:0] w);
    chk({tag, ".valid"}, 64'(req_valid), 64'd1);
    chk({tag, ".busy"},  64'(busy), 64'd1);
    chk({tag, ".we"},    64'(req_we), 64'(we));
    chk({tag, ".addr"},  req_addr, a);
    chk({tag, ".strb"},  64'(req_strb), 64'(s));
    chk({tag, ".wdata"}, req_wdata, w);
  endtask

  // One LSU request; expected beats and read data are hand-computed by the caller.
  task automatic txn(input string tag, input logic rd, input logic wr,
                     input logic [63:0] a, input logic [2:0] sz, input logic [63:0] d,
                     input logic [63:0] rlo, input logic [63:0] rhi, input int stall,
                     input logic [63:0] e_alo, input logic [7:0] e_slo, input logic [63:0] e_wlo,
                     input logic e_split,
                     input logic [63:0] e_ahi, input logic [7:0] e_shi, input logic [63:0] e_whi,
                     input logic [63:0] e_rd);
    rd_en = rd; wr_en = wr; addr = a; size = sz; wr_data = d;
    chk({tag, ".busy_at_accept"}, 64'(busy), 64'd0);
    step();
    rd_en = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0;
    chk_beat({tag, ".lo"}, wr, e_alo, e_slo, e_wlo);
    for (int i = 0; i < stall; i++) begin
      step();
      chk_beat({tag, ".lo_stall"}, wr, e_alo, e_slo, e_wlo);
      chk({tag, ".rdy_stall"}, 64'(rdy), 64'd0);
    end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk({tag, ".valid_wait_lo"}, 64'(req_valid), 64'd0);
    resp_valid = 1'b1; resp_rdata = rlo;
    if (!e_split) chk({tag, ".rdy_early"}, 64'(rdy), 64'd0);
    step();
    resp_valid = 1'b0; resp_rdata = '0;
    if (e_split) begin
      chk_beat({tag, ".hi"}, wr, e_ahi, e_shi, e_whi);
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      resp_valid = 1'b1; resp_rdata = rhi;
      chk({tag, ".rdy_early"}, 64'(rdy), 64'd0);
      step();
      resp_valid = 1'b0; resp_rdata = '0;
    end
    chk({tag, ".rdy"}, 64'(rdy), 64'd1);
    chk({tag, ".busy_resp"}, 64'(busy), 64'd1);
    if (!wr) chk({tag, ".rd_data"}, rd_data, e_rd);
    step();
    chk({tag, ".rdy_once"}, 64'(rdy), 64'd0);
    chk({tag, ".busy_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; size = '0; wr_data = '0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
    step(); step();
    chk("rst.busy",  64'(busy), 64'd0);
    chk("rst.rdy",   64'(rdy), 64'd0);
    chk("rst.valid", 64'(req_valid), 64'd0);
    chk("rst.we",    64'(req_we), 64'd0);
    chk("rst.strb",  64'(req_strb), 64'd0);
    chk("rst.addr",  req_addr, 64'd0);
    chk("rst.wdata", req_wdata, 64'd0);
    chk("rst.rdata", rd_data, 64'd0);
    rst = 1'b0;
    step();

    // Aligned read.
    txn("rd_aligned", 1'b1, 1'b0, 64'h1000, 3'd0, 64'h0,
        64'h8877665544332211, 64'h0, 0,
        64'h1000, 8'hFF, 64'h0, 1'b0, 64'h0, 8'h00, 64'h0,
        64'h8877665544332211);
    // Byte store.
    txn("st_byte", 1'b0, 1'b1, 64'h2005, 3'd0, 64'hAB,
        64'h0, 64'h0, 0,
        64'h2000, 8'h20, 64'h0000AB0000000000, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0);
    // Word store crossing into the next bus word.
    txn("st_word_split", 1'b0, 1'b1, 64'h3006, 3'd2, 64'hDDCCBBAA,
        64'h0, 64'h0, 0,
        64'h3000, 8'hC0, 64'hBBAA000000000000, 1'b1, 64'h3008, 8'h03, 64'hDDCC, 64'h0);
    // Unaligned read across two bus words.
    txn("rd_split", 1'b1, 1'b0, 64'h4003, 3'd0, 64'h0,
        64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 0,
        64'h4000, 8'hFF, 64'h0, 1'b1, 64'h4008, 8'hFF, 64'h0,
        64'h0A09080706050403);
    // Half store at the last byte of a bus word.
    txn("st_half_off7", 1'b0, 1'b1, 64'h6007, 3'd1, 64'hBEEF,
        64'h0, 64'h0, 0,
        64'h6000, 8'h80, 64'hEF00000000000000, 1'b1, 64'h6008, 8'h01, 64'hBE, 64'h0);
    // Stalled bus with both strobes high (treated as a write).
    txn("stall_rdwr", 1'b1, 1'b1, 64'h5000, 3'd3, 64'h1122334455667788,
        64'h0, 64'h0, 4,
        64'h5000, 8'hFF, 64'h1122334455667788, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0);

    // Reset while waiting for the lo response; the late response must be ignored.
    rd_en = 1'b1; addr = 64'h7000;
    step();
    rd_en = 1'b0; addr = '0;
    chk("rst_mid.valid", 64'(req_valid), 64'd1);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("rst_mid.waiting", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid.busy",  64'(busy), 64'd0);
    chk("rst_mid.valid0", 64'(req_valid), 64'd0);
    chk("rst_mid.addr",  req_addr, 64'd0);
    chk("rst_mid.strb",  64'(req_strb), 64'd0);
    step();
    rst = 1'b0;
    resp_valid = 1'b1; resp_rdata = 64'hDEADBEEFDEADBEEF;
    step();
    resp_valid = 1'b0; resp_rdata = '0;
    chk("stale_resp.rdy",   64'(rdy), 64'd0);
    chk("stale_resp.busy",  64'(busy), 64'd0);
    chk("stale_resp.valid", 64'(req_valid), 64'd0);
    step();
    chk("stale_resp.rdy2",  64'(rdy), 64'd0);

    // Doubleword store at the top of the address space wraps the hi beat to 0.
    txn("st_wrap", 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 64'h0123456789ABCDEF,
        64'h0, 64'h0, 0,
        64'hFFFF_FFFF_FFFF_FFF8, 8'hF0, 64'h89ABCDEF00000000,
        1'b1, 64'h0, 8'h0F, 64'h01234567, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
